// File: rtl/iir_biquad_seq_pkg.sv
// Shared codes and defaults for the FiltroRecursivo biquad path.
// Holds the band, coefficient-index and state encodings and the default word sizes.
package iir_biquad_seq_pkg;

  localparam int DEF_WIDTH = 22;
  localparam int DEF_FRAC  = 14;

  typedef enum logic [1:0] {
    BAND_OFF   = 2'd0,
    BAND_BAJO  = 2'd1,
    BAND_MEDIO = 2'd2,
    BAND_ALTO  = 2'd3
  } band_e;

  typedef enum logic [2:0] {
    IDX_B0 = 3'd0,
    IDX_B1 = 3'd1,
    IDX_B2 = 3'd2,
    IDX_A1 = 3'd3,
    IDX_A2 = 3'd4
  } coef_idx_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2
  } state_e;

endpackage

// File: rtl/iir_biquad_seq_round_sat.sv
// Combinational round-half-up (toward +infinity) and saturation from an accumulator
// with FRAC fractional bits down to a WIDTH-bit signed sample.
module round_sat
  import iir_biquad_seq_pkg::*;
#(
  parameter int ACC_W = 2 * DEF_WIDTH + 3,
  parameter int FRAC  = DEF_FRAC,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic signed [ACC_W-1:0] acc_i,
  output logic signed [WIDTH-1:0] y_o
);

  localparam logic signed [ACC_W:0] RND_C =
    {{(ACC_W + 1 - FRAC){1'b0}}, 1'b1, {(FRAC - 1){1'b0}}};
  localparam logic signed [ACC_W:0] MAX_C =
    {{(ACC_W + 2 - WIDTH){1'b0}}, {(WIDTH - 1){1'b1}}};
  localparam logic signed [ACC_W:0] MIN_C =
    {{(ACC_W + 2 - WIDTH){1'b1}}, {(WIDTH - 1){1'b0}}};

  logic signed [ACC_W:0] sum_s;
  logic signed [ACC_W:0] shifted_s;

  // One guard bit keeps the rounding add from wrapping before the shift.
  always_comb begin
    sum_s     = {acc_i[ACC_W-1], acc_i} + RND_C;
    shifted_s = sum_s >>> FRAC;
    if (shifted_s > MAX_C) begin
      y_o = MAX_C[WIDTH-1:0];
    end else if (shifted_s < MIN_C) begin
      y_o = MIN_C[WIDTH-1:0];
    end else begin
      y_o = shifted_s[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/iir_biquad_seq.sv
// Time-multiplexed direct-form-I biquad: one MAC over five cycles per sample,
// coefficients fetched from the external mux bank via {sel, coef_idx}.
module iir_biquad_seq
  import iir_biquad_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int FRAC  = DEF_FRAC,
  parameter int ACC_W = 2 * WIDTH + 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              band,
  input  logic signed [WIDTH-1:0] x_in,
  input  logic                    sample_valid,
  output logic [1:0]              sel,
  output logic [2:0]              coef_idx,
  input  logic signed [WIDTH-1:0] coef_in,
  output logic signed [WIDTH-1:0] y_out,
  output logic                    y_valid,
  output logic                    busy,
  output logic                    overrun
);

  state_e                  state_q;
  logic [1:0]              sel_q;
  logic [2:0]              coef_idx_q;
  logic signed [WIDTH-1:0] x0_q;
  logic signed [WIDTH-1:0] x1_q;
  logic signed [WIDTH-1:0] x2_q;
  logic signed [WIDTH-1:0] y1_q;
  logic signed [WIDTH-1:0] y2_q;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [WIDTH-1:0] y_out_q;
  logic                    y_valid_q;
  logic                    busy_q;
  logic                    overrun_q;

  logic signed [WIDTH:0]   operand_s;
  logic signed [2*WIDTH:0] product_s;
  logic signed [ACC_W-1:0] acc_d;
  logic signed [WIDTH-1:0] y_sat_s;

  // Operand is one bit wider than a sample so that negating -2^(WIDTH-1) cannot wrap.
  always_comb begin
    operand_s = '0;
    case (coef_idx_q)
      IDX_B0:  operand_s = {x0_q[WIDTH-1], x0_q};
      IDX_B1:  operand_s = {x1_q[WIDTH-1], x1_q};
      IDX_B2:  operand_s = {x2_q[WIDTH-1], x2_q};
      IDX_A1:  operand_s = -{y1_q[WIDTH-1], y1_q};
      IDX_A2:  operand_s = -{y2_q[WIDTH-1], y2_q};
      default: operand_s = '0;
    endcase
  end

  assign product_s = $signed({{(WIDTH + 1){coef_in[WIDTH-1]}}, coef_in}) *
                     $signed({{WIDTH{operand_s[WIDTH]}}, operand_s});
  assign acc_d     = acc_q + {{(ACC_W - 2 * WIDTH - 1){product_s[2*WIDTH]}}, product_s};

  round_sat #(
    .ACC_W (ACC_W),
    .FRAC  (FRAC),
    .WIDTH (WIDTH)
  ) u_round_sat (
    .acc_i (acc_q),
    .y_o   (y_sat_s)
  );

  // Sequencer: accept, five MAC cycles, round/saturate and shift the history.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      sel_q      <= 2'd0;
      coef_idx_q <= 3'd0;
      x0_q       <= '0;
      x1_q       <= '0;
      x2_q       <= '0;
      y1_q       <= '0;
      y2_q       <= '0;
      acc_q      <= '0;
      y_out_q    <= '0;
      y_valid_q  <= 1'b0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      y_valid_q <= 1'b0;
      if (sample_valid && busy_q) begin
        overrun_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          coef_idx_q <= IDX_B0;
          if (sample_valid) begin
            x0_q    <= x_in;
            sel_q   <= band;
            acc_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_MAC;
            // A different band means the old history belongs to another filter.
            if (band != sel_q) begin
              x1_q <= '0;
              x2_q <= '0;
              y1_q <= '0;
              y2_q <= '0;
            end
          end
        end
        ST_MAC: begin
          acc_q <= acc_d;
          if (coef_idx_q == IDX_A2) begin
            coef_idx_q <= IDX_B0;
            state_q    <= ST_OUT;
          end else begin
            coef_idx_q <= coef_idx_q + 3'd1;
          end
        end
        ST_OUT: begin
          y_out_q   <= y_sat_s;
          y_valid_q <= 1'b1;
          x2_q      <= x1_q;
          x1_q      <= x0_q;
          y2_q      <= y1_q;
          y1_q      <= y_sat_s;
          busy_q    <= 1'b0;
          state_q   <= ST_IDLE;
        end
        default: begin
          coef_idx_q <= IDX_B0;
          busy_q     <= 1'b0;
          state_q    <= ST_IDLE;
        end
      endcase
    end
  end

  assign sel      = sel_q;
  assign coef_idx = coef_idx_q;
  assign y_out    = y_out_q;
  assign y_valid  = y_valid_q;
  assign busy     = busy_q;
  assign overrun  = overrun_q;

endmodule
